// File: rtl/jtframe_ddr_rdarb.sv
// jtframe_ddr_rdarb
// Shares the DDR3 burst-read port between two requesters (A: ROM fetcher,
// B: secondary loader). Requests are latched, granted round-robin, issued
// one burst at a time, and beats are routed to the owner. A stalled burst
// is abandoned after 2**TW-1 beat-less cycles.
module jtframe_ddr_rdarb #(
  parameter int          TW    = 5,
  parameter logic [3:0]  ABASE = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_rd,
  input  logic [28:0] a_addr,
  input  logic [7:0]  a_burstcnt,
  output logic        a_busy,
  output logic        a_dout_ready,
  output logic        a_err,
  input  logic        b_rd,
  input  logic [28:0] b_addr,
  input  logic [7:0]  b_burstcnt,
  output logic        b_busy,
  output logic        b_dout_ready,
  output logic        b_err,
  input  logic        ddram_busy,
  output logic        ddram_rd,
  output logic [28:0] ddram_addr,
  output logic [7:0]  ddram_burstcnt,
  input  logic        ddram_dout_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DATA} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  // Timeout fires when the counter is about to reach all-ones.
  localparam logic [TW-1:0] TO_LAST = {{(TW-1){1'b1}}, 1'b0};

  state_t      r_state;
  state_t      w_state_n;
  owner_t      r_owner;
  logic        r_last_b;
  logic        r_pend_a, r_pend_b;
  logic [24:0] r_addr_a, r_addr_b;
  logic [7:0]  r_len_a, r_len_b;
  logic        r_rd;
  logic [28:0] r_daddr;
  logic [7:0]  r_dlen;
  logic [7:0]  r_beats;
  logic [TW-1:0] r_to;
  logic        r_err_a, r_err_b;

  logic w_busy_a, w_busy_b;
  logic w_cap_a, w_cap_b, w_zero_a, w_zero_b;
  logic w_grant_a, w_grant_b, w_accept, w_beat, w_done, w_abort;
  logic w_unused_hi;

  // The window bits come from ABASE, so the requesters' top address bits are not stored.
  assign w_unused_hi = ^{a_addr[28:25], b_addr[28:25]};

  assign w_busy_a = r_pend_a | (r_owner == OWN_A);
  assign w_busy_b = r_pend_b | (r_owner == OWN_B);

  assign w_cap_a  = a_rd & ~w_busy_a & (a_burstcnt != 8'd0);
  assign w_cap_b  = b_rd & ~w_busy_b & (b_burstcnt != 8'd0);
  assign w_zero_a = a_rd & ~w_busy_a & (a_burstcnt == 8'd0);
  assign w_zero_b = b_rd & ~w_busy_b & (b_burstcnt == 8'd0);

  assign a_busy         = w_busy_a;
  assign b_busy         = w_busy_b;
  assign a_err          = r_err_a;
  assign b_err          = r_err_b;
  assign ddram_rd       = r_rd;
  assign ddram_addr     = r_daddr;
  assign ddram_burstcnt = r_dlen;

  // Beats are only forwarded while a burst is in its data phase; stray beats are dropped.
  assign a_dout_ready = ddram_dout_ready & (r_state == ST_DATA) & (r_owner == OWN_A);
  assign b_dout_ready = ddram_dout_ready & (r_state == ST_DATA) & (r_owner == OWN_B);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  // Next state plus the one-cycle events that drive the datapath registers.
  always_comb begin
    w_state_n = r_state;
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    w_accept  = 1'b0;
    w_beat    = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_a & (~r_pend_b | r_last_b)) begin
          w_grant_a = 1'b1;
          w_state_n = ST_ISSUE;
        end else if (r_pend_b) begin
          w_grant_b = 1'b1;
          w_state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!ddram_busy) begin
          w_accept  = 1'b1;
          w_state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ddram_dout_ready) begin
          w_beat = 1'b1;
          if (r_beats == 8'd1) begin
            w_done    = 1'b1;
            w_state_n = ST_IDLE;
          end
        end else if (r_to == TO_LAST) begin
          w_abort   = 1'b1;
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Request capture, grant bookkeeping, DDR command and beat/timeout counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= OWN_NONE;
      r_last_b <= 1'b1;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_len_a  <= '0;
      r_len_b  <= '0;
      r_rd     <= 1'b0;
      r_daddr  <= '0;
      r_dlen   <= '0;
      r_beats  <= '0;
      r_to     <= '0;
      r_err_a  <= 1'b0;
      r_err_b  <= 1'b0;
    end else begin
      r_err_a <= w_zero_a | (w_abort & (r_owner == OWN_A));
      r_err_b <= w_zero_b | (w_abort & (r_owner == OWN_B));

      if (w_cap_a) begin
        r_pend_a <= 1'b1;
        r_addr_a <= a_addr[24:0];
        r_len_a  <= a_burstcnt;
      end
      if (w_cap_b) begin
        r_pend_b <= 1'b1;
        r_addr_b <= b_addr[24:0];
        r_len_b  <= b_burstcnt;
      end

      if (w_grant_a) begin
        r_owner  <= OWN_A;
        r_last_b <= 1'b0;
        r_rd     <= 1'b1;
        r_daddr  <= {ABASE, r_addr_a};
        r_dlen   <= r_len_a;
      end
      if (w_grant_b) begin
        r_owner  <= OWN_B;
        r_last_b <= 1'b1;
        r_rd     <= 1'b1;
        r_daddr  <= {ABASE, r_addr_b};
        r_dlen   <= r_len_b;
      end

      if (w_accept) begin
        r_rd    <= 1'b0;
        r_beats <= r_dlen;
        r_to    <= '0;
        if (r_owner == OWN_A) r_pend_a <= 1'b0;
        if (r_owner == OWN_B) r_pend_b <= 1'b0;
      end

      if (w_beat) begin
        r_beats <= r_beats - 8'd1;
        r_to    <= '0;
      end else if (r_state == ST_DATA) begin
        r_to <= r_to + 1'b1;
      end

      if (w_done | w_abort) r_owner <= OWN_NONE;
    end
  end

endmodule

// File: tb/tb_jtframe_ddr_rdarb.sv
// Testbench for jtframe_ddr_rdarb: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_jtframe_ddr_rdarb;

  localparam int         TW    = 5;
  localparam logic [3:0] ABASE = 4'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_rd = 1'b0, b_rd = 1'b0;
  logic [28:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_burstcnt = '0, b_burstcnt = '0;
  logic        a_busy, a_dout_ready, a_err;
  logic        b_busy, b_dout_ready, b_err;
  logic        ddram_busy = 1'b0;
  logic        ddram_rd;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt;
  logic        ddram_dout_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  jtframe_ddr_rdarb #(.TW(TW), .ABASE(ABASE)) dut (
    .clk(clk), .rst(rst),
    .a_rd(a_rd), .a_addr(a_addr), .a_burstcnt(a_burstcnt),
    .a_busy(a_busy), .a_dout_ready(a_dout_ready), .a_err(a_err),
    .b_rd(b_rd), .b_addr(b_addr), .b_burstcnt(b_burstcnt),
    .b_busy(b_busy), .b_dout_ready(b_dout_ready), .b_err(b_err),
    .ddram_busy(ddram_busy), .ddram_rd(ddram_rd), .ddram_addr(ddram_addr),
    .ddram_burstcnt(ddram_burstcnt), .ddram_dout_ready(ddram_dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ports indexed 0 (A) and 1 (B); owner 0 = nobody, 1 = A, 2 = B.
  // Phase 0 = waiting for work, 1 = command on the bus, 2 = collecting beats.
  bit          m_pend[2];
  logic [28:0] m_addr[2];
  logic [7:0]  m_len[2];
  int          m_owner, m_phase, m_left, m_quiet;
  bit          m_lastB, m_rd;
  logic [28:0] m_oaddr;
  logic [7:0]  m_olen;
  bit          m_err[2];
  bit          mb[2];
  bit          ne[2];
  int          mw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend[0] = 0; m_pend[1] = 0;
      m_addr[0] = '0; m_addr[1] = '0;
      m_len[0] = '0; m_len[1] = '0;
      m_owner = 0; m_phase = 0; m_left = 0; m_quiet = 0;
      m_lastB = 1; m_rd = 0; m_oaddr = '0; m_olen = '0;
      m_err[0] = 0; m_err[1] = 0;
    end else begin
      mb[0] = m_pend[0] || m_owner == 1;
      mb[1] = m_pend[1] || m_owner == 2;
      ne[0] = 0; ne[1] = 0;
      if (m_phase == 0) begin
        if (m_pend[0] || m_pend[1]) begin
          mw = (m_pend[0] && (!m_pend[1] || m_lastB)) ? 0 : 1;
          m_owner = mw + 1;
          m_lastB = (mw == 1);
          m_rd = 1;
          m_oaddr = {ABASE, m_addr[mw][24:0]};
          m_olen = m_len[mw];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!ddram_busy) begin
          m_rd = 0;
          m_left = m_olen;
          m_pend[m_owner-1] = 0;
          m_quiet = 0;
          m_phase = 2;
        end
      end else begin
        if (ddram_dout_ready) begin
          m_quiet = 0;
          m_left = m_left - 1;
          if (m_left == 0) begin m_owner = 0; m_phase = 0; end
        end else begin
          m_quiet = m_quiet + 1;
          if (m_quiet == (2**TW) - 1) begin
            ne[m_owner-1] = 1;
            m_owner = 0;
            m_phase = 0;
          end
        end
      end
      if (a_rd && !mb[0]) begin
        if (a_burstcnt == 0) ne[0] = 1;
        else begin m_pend[0] = 1; m_addr[0] = a_addr; m_len[0] = a_burstcnt; end
      end
      if (b_rd && !mb[1]) begin
        if (b_burstcnt == 0) ne[1] = 1;
        else begin m_pend[1] = 1; m_addr[1] = b_addr; m_len[1] = b_burstcnt; end
      end
      m_err[0] = ne[0];
      m_err[1] = ne[1];
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ddram_rd", {31'd0, ddram_rd}, {31'd0, m_rd});
      chk("ddram_addr", {3'd0, ddram_addr}, {3'd0, m_oaddr});
      chk("ddram_burstcnt", {24'd0, ddram_burstcnt}, {24'd0, m_olen});
      chk("a_busy", {31'd0, a_busy}, {31'd0, (m_pend[0] || m_owner == 1)});
      chk("b_busy", {31'd0, b_busy}, {31'd0, (m_pend[1] || m_owner == 2)});
      chk("a_err", {31'd0, a_err}, {31'd0, m_err[0]});
      chk("b_err", {31'd0, b_err}, {31'd0, m_err[1]});
      chk("a_dout_ready", {31'd0, a_dout_ready},
          {31'd0, (ddram_dout_ready && m_phase == 2 && m_owner == 1)});
      chk("b_dout_ready", {31'd0, b_dout_ready},
          {31'd0, (ddram_dout_ready && m_phase == 2 && m_owner == 2)});
    end
  end

  // ---------------- directed stimulus ----------------
  int na, nb, found, rds;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      ddram_dout_ready = 1'b1;
      #1;
      if (a_dout_ready) na++;
      if (b_dout_ready) nb++;
      tick();
    end
    ddram_dout_ready = 1'b0;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst ddram_rd", {31'd0, ddram_rd}, 32'd0);
    chk("rst ddram_addr", {3'd0, ddram_addr}, 32'd0);
    chk("rst ddram_burstcnt", {24'd0, ddram_burstcnt}, 32'd0);
    chk("rst a_busy", {31'd0, a_busy}, 32'd0);
    chk("rst b_busy", {31'd0, b_busy}, 32'd0);
    chk("rst a_err", {31'd0, a_err}, 32'd0);
    chk("rst b_err", {31'd0, b_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Tie on reset: A wins, then B.
    a_addr = 29'h200; a_burstcnt = 8'd2; b_addr = 29'h300; b_burstcnt = 8'd2;
    a_rd = 1'b1; b_rd = 1'b1;
    tick();
    a_rd = 1'b0; b_rd = 1'b0;
    chk("tie1 a_busy", {31'd0, a_busy}, 32'd1);
    chk("tie1 b_busy", {31'd0, b_busy}, 32'd1);
    tick();
    chk("tie1 first rd", {31'd0, ddram_rd}, 32'd1);
    chk("tie1 first addr", {3'd0, ddram_addr}, 32'h200);
    tick();
    na = 0; nb = 0;
    beats(2);
    chk("tie1 A beats", na, 32'd2);
    chk("tie1 B beats early", nb, 32'd0);
    tick();
    chk("tie1 second rd", {31'd0, ddram_rd}, 32'd1);
    chk("tie1 second addr", {3'd0, ddram_addr}, 32'h300);
    tick();
    beats(2);
    chk("tie1 B beats", nb, 32'd2);
    tick();

    // Single A request: rd one cycle, two edges after a_rd.
    a_addr = 29'h100; a_burstcnt = 8'd4;
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    chk("t1 rd after 1 edge", {31'd0, ddram_rd}, 32'd0);
    chk("t1 a_busy", {31'd0, a_busy}, 32'd1);
    tick();
    chk("t1 rd after 2 edges", {31'd0, ddram_rd}, 32'd1);
    chk("t1 addr", {3'd0, ddram_addr}, 32'h100);
    chk("t1 burstcnt", {24'd0, ddram_burstcnt}, 32'd4);
    tick();
    chk("t1 rd dropped", {31'd0, ddram_rd}, 32'd0);
    na = 0; nb = 0;
    beats(4);
    chk("t1 A beats", na, 32'd4);
    chk("t1 a_busy after", {31'd0, a_busy}, 32'd0);
    tick();

    // Repeated tie after an A grant: B wins first.
    a_addr = 29'h210; a_burstcnt = 8'd2; b_addr = 29'h310; b_burstcnt = 8'd2;
    a_rd = 1'b1; b_rd = 1'b1;
    tick();
    a_rd = 1'b0; b_rd = 1'b0;
    tick();
    chk("tie2 first addr", {3'd0, ddram_addr}, 32'h310);
    tick();
    na = 0; nb = 0;
    beats(2);
    chk("tie2 B beats", nb, 32'd2);
    chk("tie2 A beats early", na, 32'd0);
    tick();
    chk("tie2 second addr", {3'd0, ddram_addr}, 32'h210);
    tick();
    beats(2);
    chk("tie2 A beats", na, 32'd2);
    tick();

    // ddram_busy stalls the command; upper address bits replaced by ABASE.
    ddram_busy = 1'b1;
    a_addr = 29'h1F000123; a_burstcnt = 8'd3;
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    tick();
    chk("t3 rd", {31'd0, ddram_rd}, 32'd1);
    chk("t3 addr", {3'd0, ddram_addr}, 32'h01000123);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3 rd held", {31'd0, ddram_rd}, 32'd1);
      chk("t3 addr held", {3'd0, ddram_addr}, 32'h01000123);
      chk("t3 cnt held", {24'd0, ddram_burstcnt}, 32'd3);
    end
    ddram_busy = 1'b0;
    tick();
    chk("t3 accepted", {31'd0, ddram_rd}, 32'd0);
    beats(3);
    tick();

    // B burst of 8 stalls after 3 beats: timeout then stray beat.
    b_addr = 29'h400; b_burstcnt = 8'd8;
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    tick();
    chk("t4 addr", {3'd0, ddram_addr}, 32'h400);
    tick();
    na = 0; nb = 0;
    beats(3);
    chk("t4 B beats", nb, 32'd3);
    found = 0;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      tick();
      if (b_err) found = k;
    end
    chk("t4 timeout edges", found, 32'd31);
    chk("t4 b_busy after abort", {31'd0, b_busy}, 32'd0);
    tick();
    chk("t4 b_err one cycle", {31'd0, b_err}, 32'd0);
    ddram_dout_ready = 1'b1;
    #1;
    chk("t4 stray b_dout_ready", {31'd0, b_dout_ready}, 32'd0);
    chk("t4 stray a_dout_ready", {31'd0, a_dout_ready}, 32'd0);
    tick();
    ddram_dout_ready = 1'b0;
    tick();

    // Zero-length request and request while busy.
    a_burstcnt = 8'd0; a_addr = 29'h480;
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    chk("t5 a_err", {31'd0, a_err}, 32'd1);
    chk("t5 a_busy", {31'd0, a_busy}, 32'd0);
    tick();
    chk("t5 a_err cleared", {31'd0, a_err}, 32'd0);
    chk("t5 no rd", {31'd0, ddram_rd}, 32'd0);
    tick();
    chk("t5 still no rd", {31'd0, ddram_rd}, 32'd0);
    a_addr = 29'h500; a_burstcnt = 8'd2;
    a_rd = 1'b1;
    tick();
    a_addr = 29'h600;
    tick();
    a_rd = 1'b0;
    chk("t5 busy addr", {3'd0, ddram_addr}, 32'h500);
    tick();
    na = 0;
    beats(2);
    chk("t5 beats", na, 32'd2);
    rds = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ddram_rd) rds++;
    end
    chk("t5 no second burst", rds, 32'd0);
    chk("t5 a_busy idle", {31'd0, a_busy}, 32'd0);

    // Reset during a data phase.
    a_addr = 29'h700; a_burstcnt = 8'd4;
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    tick();
    tick();
    beats(1);
    chk("t6 a_busy before rst", {31'd0, a_busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6 rd async", {31'd0, ddram_rd}, 32'd0);
    chk("t6 a_busy async", {31'd0, a_busy}, 32'd0);
    chk("t6 b_busy async", {31'd0, b_busy}, 32'd0);
    chk("t6 addr async", {3'd0, ddram_addr}, 32'd0);
    ddram_dout_ready = 1'b1;
    #1;
    chk("t6 beat in rst", {31'd0, a_dout_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("t6 beat after rst", {31'd0, a_dout_ready}, 32'd0);
    tick();
    chk("t6 beat later", {31'd0, a_dout_ready}, 32'd0);
    ddram_dout_ready = 1'b0;
    chk("t6 a_busy idle", {31'd0, a_busy}, 32'd0);
    tick();

    // Reset while a command is stalled on the bus.
    ddram_busy = 1'b1;
    b_addr = 29'h800; b_burstcnt = 8'd1;
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    tick();
    chk("t6b rd before rst", {31'd0, ddram_rd}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6b rd async", {31'd0, ddram_rd}, 32'd0);
    chk("t6b b_busy async", {31'd0, b_busy}, 32'd0);
    ddram_busy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
